tdm_demux4_rx: RTL and testbench



---
 rtl/tdm_demux4_rx.sv | 107 ++++++++++
 tb/tb_tdm_demux4_rx.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/tdm_demux4_rx.sv
// 4-slot bit-interleaved TDM receiver: splits one serial stream
// into four DATA_W-bit channel words, MSB first.
module tdm_demux4_rx #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              din,
  input  logic              din_valid,
  input  logic              frame_sync,
  output logic [DATA_W-1:0] q0,
  output logic [DATA_W-1:0] q1,
  output logic [DATA_W-1:0] q2,
  output logic [DATA_W-1:0] q3,
  output logic [3:0]        q_valid,
  output logic [1:0]        slot,
  output logic              locked,
  output logic              sync_err
);

  localparam int SW = DATA_W - 1;
  localparam int CW = $clog2(DATA_W);
  localparam logic [CW-1:0] LAST = CW'(DATA_W - 1);

  typedef enum logic {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [1:0]        slot_q, slot_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [SW-1:0]     sh_q [4];
  logic [SW-1:0]     sh_d [4];
  logic [DATA_W-1:0] qw_q [4];
  logic [DATA_W-1:0] qw_d [4];
  logic [3:0]        qv_q, qv_d;
  logic              err_q, err_d;

  logic [DATA_W-1:0] word;
  logic              aligned;

  // shift register holds the upper bits; the live bit completes the word
  assign word    = {sh_q[slot_q], din};
  assign aligned = (state_q == LOCKED) && (slot_q == 2'd0)
                   && (cnt_q == '0);

  always_comb begin
    state_d = state_q;
    slot_d  = slot_q;
    cnt_d   = cnt_q;
    sh_d    = sh_q;
    qw_d    = qw_q;
    qv_d    = '0;
    err_d   = 1'b0;
    if (din_valid) begin
      if (frame_sync && !aligned) begin
        err_d = (state_q == LOCKED);
        for (int k = 0; k < 4; k++) sh_d[k] = '0;
        sh_d[0] = SW'(din);
        state_d = LOCKED;
        slot_d  = 2'd1;
        cnt_d   = '0;
      end else if (state_q == LOCKED) begin
        sh_d[slot_q] = word[SW-1:0];
        slot_d       = slot_q + 2'd1;
        if (cnt_q == LAST) begin
          qw_d[slot_q] = word;
          qv_d[slot_q] = 1'b1;
        end
        if (slot_q == 2'd3) begin
          cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= HUNT;
      slot_q  <= '0;
      cnt_q   <= '0;
      sh_q    <= '{default: '0};
      qw_q    <= '{default: '0};
      qv_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      slot_q  <= slot_d;
      cnt_q   <= cnt_d;
      sh_q    <= sh_d;
      qw_q    <= qw_d;
      qv_q    <= qv_d;
      err_q   <= err_d;
    end
  end

  assign q0       = qw_q[0];
  assign q1       = qw_q[1];
  assign q2       = qw_q[2];
  assign q3       = qw_q[3];
  assign q_valid  = qv_q;
  assign slot     = slot_q;
  assign locked   = (state_q == LOCKED);
  assign sync_err = err_q;

endmodule

// File: tb/tb_tdm_demux4_rx.sv
// Randomized + directed bench for tdm_demux4_rx with a frame-position
// reference model feeding a cycle-stamped scoreboard.
module tb_tdm_demux4_rx;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst, din, din_valid, frame_sync;
  logic [W-1:0] q0, q1, q2, q3;
  logic [3:0]   q_valid;
  logic [1:0]   slot;
  logic         locked, sync_err;

  always #5 clk = ~clk;

  tdm_demux4_rx #(.DATA_W(W)) dut (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid),
    .frame_sync(frame_sync), .q0(q0), .q1(q1), .q2(q2), .q3(q3),
    .q_valid(q_valid), .slot(slot), .locked(locked),
    .sync_err(sync_err)
  );

  typedef struct {
    int cyc;
    int ch;
    int val;
  } exp_t;

  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;
  exp_t dq[$];
  int   eq[$];

  // model: frame position 0..4W-1, channel = pos%4, bit = pos/4
  bit   m_locked;
  int   m_pos;
  int   acc[4];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)",
               nm, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] getq(input int ch);
    case (ch)
      0: return 32'(q0);
      1: return 32'(q1);
      2: return 32'(q2);
      default: return 32'(q3);
    endcase
  endfunction

  task automatic model_reset();
    m_locked = 1'b0;
    m_pos    = 0;
    acc      = '{default: 0};
  endtask

  task automatic model_step(input logic b, input logic s);
    int ch;
    if (s && !(m_locked && m_pos == 0)) begin
      if (m_locked) eq.push_back(cyc + 1);
      m_locked = 1'b1;
      acc      = '{default: 0};
      acc[0]   = int'(b);
      m_pos    = 1;
    end else if (m_locked) begin
      ch      = m_pos % 4;
      acc[ch] = acc[ch] * 2 + int'(b);
      if (m_pos / 4 == W - 1) begin
        dq.push_back('{cyc + 1, ch, acc[ch]});
        acc[ch] = 0;
      end
      m_pos = (m_pos + 1) % (4 * W);
    end
  endtask

  task automatic send(input logic b, input logic v, input logic s);
    din        = b;
    din_valid  = v;
    frame_sync = s;
    if (v) model_step(b, s);
    @(posedge clk);
    #1;
    chk("slot", 32'(slot), 32'(m_locked ? m_pos % 4 : 0));
    chk("locked", 32'(locked), 32'(m_locked));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) send(1'b0, 1'b0, 1'b0);
  endtask

  task automatic rbit(output logic b);
    b = logic'($urandom_range(1));
  endtask

  task automatic send_frame(input logic [W-1:0] w0, w1, w2, w3,
                            input bit sync, input int gap);
    logic [W-1:0] w[4];
    logic         r, rs;
    w = '{w0, w1, w2, w3};
    for (int b = 0; b < W; b++) begin
      for (int ch = 0; ch < 4; ch++) begin
        rbit(r);
        rbit(rs);
        if (gap == 1 || (gap == 2 && $urandom_range(3) == 0))
          send(r, 1'b0, rs);
        send(w[ch][W-1-b], 1'b1, sync && b == 0 && ch == 0);
      end
    end
  endtask

  task automatic check_q(input logic [W-1:0] a, b, c, d);
    chk("q0_hold", 32'(q0), 32'(a));
    chk("q1_hold", 32'(q1), 32'(b));
    chk("q2_hold", 32'(q2), 32'(c));
    chk("q3_hold", 32'(q3), 32'(d));
  endtask

  task automatic do_reset();
    rst        = 1'b1;
    din        = 1'b0;
    din_valid  = 1'b0;
    frame_sync = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    chk("rst_q0", 32'(q0), 0);
    chk("rst_q1", 32'(q1), 0);
    chk("rst_q2", 32'(q2), 0);
    chk("rst_q3", 32'(q3), 0);
    chk("rst_qvalid", 32'(q_valid), 0);
    chk("rst_slot", 32'(slot), 0);
    chk("rst_locked", 32'(locked), 0);
    chk("rst_sync_err", 32'(sync_err), 0);
  endtask

  // monitor: pops the scoreboard whenever the DUT presents a word
  always @(negedge clk) begin
    exp_t e;
    int   ec;
    if (!rst) begin
      chk("qv_onehot", 32'($onehot0(q_valid)), 1);
      if (q_valid != 4'd0) begin
        if (dq.size() == 0) begin
          chk("unexp_qvalid", 32'(q_valid), 0);
        end else begin
          e = dq.pop_front();
          chk("qv_cycle", 32'(cyc), 32'(e.cyc));
          chk("qv_chan", 32'(q_valid), 32'(1 << e.ch));
          chk("q_word", getq(e.ch), 32'(e.val));
        end
      end else if (dq.size() > 0 && dq[0].cyc <= cyc) begin
        e = dq.pop_front();
        chk("missed_qvalid", 32'(q_valid), 32'(1 << e.ch));
      end
      if (sync_err) begin
        if (eq.size() == 0) begin
          chk("unexp_sync_err", 32'(sync_err), 0);
        end else begin
          ec = eq.pop_front();
          chk("sync_err_cycle", 32'(cyc), 32'(ec));
        end
      end else if (eq.size() > 0 && eq[0] <= cyc) begin
        ec = eq.pop_front();
        chk("missed_sync_err", 32'(sync_err), 1);
      end
    end
  end

  initial begin
    logic         r;
    logic [W-1:0] rw[4];
    do_reset();

    for (int i = 0; i < 4; i++) begin
      rbit(r);
      send(r, 1'b1, 1'b0);
    end
    chk("hunt_locked", 32'(locked), 0);

    send_frame(8'hA5, 8'h3C, 8'hFF, 8'h01, 1'b1, 0);
    idle(2);
    check_q(8'hA5, 8'h3C, 8'hFF, 8'h01);

    do_reset();
    send_frame(8'hA5, 8'h3C, 8'hFF, 8'h01, 1'b1, 1);
    idle(2);
    check_q(8'hA5, 8'h3C, 8'hFF, 8'h01);

    send_frame(8'hA5, 8'h3C, 8'hFF, 8'h01, 1'b1, 0);
    send_frame(8'h12, 8'h34, 8'h56, 8'h78, 1'b0, 0);
    idle(2);
    check_q(8'h12, 8'h34, 8'h56, 8'h78);

    // resync lands on slot 2, bit 3
    for (int i = 0; i < 14; i++) begin
      rbit(r);
      send(r, 1'b1, 1'b0);
    end
    send_frame(8'h0F, 8'hF0, 8'h55, 8'hAA, 1'b1, 0);
    idle(2);
    check_q(8'h0F, 8'hF0, 8'h55, 8'hAA);

    for (int i = 0; i < 20; i++) begin
      rbit(r);
      send(r, 1'b1, 1'b0);
    end
    do_reset();
    idle(3);
    send_frame(8'hC3, 8'h81, 8'h7E, 8'h00, 1'b1, 0);
    idle(2);
    check_q(8'hC3, 8'h81, 8'h7E, 8'h00);

    for (int i = 0; i < 400; i++) begin
      rbit(r);
      send(r, logic'($urandom_range(3) != 0),
           logic'($urandom_range(29) == 0));
    end
    idle(2);

    for (int f = 0; f < 4; f++) begin
      for (int k = 0; k < 4; k++) rw[k] = W'($urandom);
      send_frame(rw[0], rw[1], rw[2], rw[3], f == 0, 2);
      idle(2);
      check_q(rw[0], rw[1], rw[2], rw[3]);
    end

    idle(3);
    chk("data_queue_empty", 32'(dq.size()), 0);
    chk("err_queue_empty", 32'(eq.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
